izh_dw_pipe: RTL and testbench

Pipelined, parametrised multi-channel recovery-variable updater for the Izhikevich core. It computes dw = a·(b·v − w)·step in signed fixed point and optionally returns the accumulated next state w + dw. It is built as a 4-stage valid/ready pipeline with a channel tag. It sits between the neuron-state RAM read port and the write-back mux, and lets one datapath serve many time-multiplexed neurons.

---
 rtl/izh_dw_pipe_pkg.sv | 45 ++++
 rtl/izh_dw_pipe_if.sv | 30 +++
 rtl/izh_dw_pipe_fx_mult_sat.sv | 25 ++
 rtl/izh_dw_pipe.sv | 94 +++++++++
 tb/tb_izh_dw_pipe.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/izh_dw_pipe_pkg.sv
// Fixed-point types and helpers shared by the Izhikevich datapath blocks.
// Stage payload fields are sized for the widest supported word and channel tag.
package izh_fixed_pkg;

  localparam int LATENCY  = 4;
  localparam int N_DEF    = 18;
  localparam int Q_DEF    = 8;
  localparam int CH_W_DEF = 8;
  localparam int N_MAX    = 32;
  localparam int CH_W_MAX = 16;
  localparam int W_RED    = 2 * N_MAX;

  typedef struct packed {
    logic             ovf;
    logic [W_RED-1:0] val;
  } red_t;

  typedef struct packed {
    logic                valid;
    logic                ovf;
    logic [CH_W_MAX-1:0] ch;
    logic [N_MAX-1:0]    a;
    logic [N_MAX-1:0]    w;
    logic [N_MAX-1:0]    step;
    logic [N_MAX-1:0]    partial;
  } stage_t;

  // Reduce a wide signed value to n bits; val comes back sign-extended to W_RED.
  function automatic red_t sat_reduce(input logic signed [W_RED-1:0] x, input int n,
                                      input bit sat);
    logic signed [W_RED-1:0] hi;
    logic signed [W_RED-1:0] lo;
    logic signed [W_RED-1:0] wrapped;
    red_t r;
    hi      = (W_RED'(1) <<< (n - 1)) - W_RED'(1);
    lo      = -hi - W_RED'(1);
    wrapped = (x <<< (W_RED - n)) >>> (W_RED - n);
    r.ovf   = (x > hi) || (x < lo);
    if (sat && (x > hi))      r.val = hi;
    else if (sat && (x < lo)) r.val = lo;
    else                      r.val = wrapped;
    return r;
  endfunction

endpackage

// File: rtl/izh_dw_pipe_if.sv
// Operand/result handshake bundle for izh_dw_pipe; master drives beats, slave is the pipe.
interface izh_dw_pipe_if #(
  parameter int N    = izh_fixed_pkg::N_DEF,
  parameter int CH_W = izh_fixed_pkg::CH_W_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_ch;
  logic signed [N-1:0] in_a;
  logic signed [N-1:0] in_b;
  logic signed [N-1:0] in_v;
  logic signed [N-1:0] in_w;
  logic signed [N-1:0] in_step;
  logic                out_valid;
  logic                out_ready;
  logic [CH_W-1:0]     out_ch;
  logic signed [N-1:0] out_data;
  logic                out_ovf;
  logic                ovf_sticky;

  modport master (
    output in_valid, in_ch, in_a, in_b, in_v, in_w, in_step, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, in_ch, in_a, in_b, in_v, in_w, in_step, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/izh_dw_pipe_fx_mult_sat.sv
// Combinational Q-format multiply: full product, floor shift by Q, clamp or wrap to N bits.
module fx_mult_sat
  import izh_fixed_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int Q        = Q_DEF,
  parameter int SATURATE = 1
) (
  input  logic signed [N-1:0] x_i,
  input  logic signed [N-1:0] y_i,
  output logic signed [N-1:0] p_o,
  output logic                ovf_o
);
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;
  red_t                  red;
  logic                  unused_red;

  assign prod       = (2*N)'(x_i) * (2*N)'(y_i);
  assign shifted    = prod >>> Q;
  assign red        = sat_reduce(W_RED'(shifted), N, SATURATE != 0);
  assign p_o        = red.val[N-1:0];
  assign ovf_o      = red.ovf;
  assign unused_red = ^red;
endmodule

// File: rtl/izh_dw_pipe.sv
// 4-stage dw = a*(b*v - w)*step updater (optionally w+dw), channel tag carried alongside.
// Latency 4, 1 beat/cycle; a stalled output (valid & !ready) freezes every stage and drops in_ready.
module izh_dw_pipe
  import izh_fixed_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int Q        = Q_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int SATURATE = 1,
  parameter int ACCUM    = 1
) (
  input logic           clk,
  input logic           reset,
  izh_dw_pipe_if.slave  bus
);
  stage_t              s1_d, s2_d, s3_d, s4_d;
  stage_t              s1_q, s2_q, s3_q, s4_q;
  logic                ovf_sticky_q;
  logic                stall;
  logic signed [N-1:0] p1, p3, dw;
  logic                ovf1, ovf3, ovf4;
  red_t                sub_r, acc_r;
  logic                unused_bits;

  assign stall        = s4_q.valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  fx_mult_sat #(.N(N), .Q(Q), .SATURATE(SATURATE)) u_mul_bv (
    .x_i(bus.in_b), .y_i(bus.in_v), .p_o(p1), .ovf_o(ovf1)
  );

  fx_mult_sat #(.N(N), .Q(Q), .SATURATE(SATURATE)) u_mul_a (
    .x_i($signed(s2_q.a[N-1:0])), .y_i($signed(s2_q.partial[N-1:0])), .p_o(p3), .ovf_o(ovf3)
  );

  fx_mult_sat #(.N(N), .Q(Q), .SATURATE(SATURATE)) u_mul_step (
    .x_i($signed(s3_q.partial[N-1:0])), .y_i($signed(s3_q.step[N-1:0])), .p_o(dw), .ovf_o(ovf4)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.valid   = bus.in_valid;
    s1_d.ch      = CH_W_MAX'(bus.in_ch);
    s1_d.a       = N_MAX'(bus.in_a);
    s1_d.w       = N_MAX'(bus.in_w);
    s1_d.step    = N_MAX'(bus.in_step);
    s1_d.partial = N_MAX'(p1);
    s1_d.ovf     = ovf1;

    sub_r = sat_reduce(W_RED'($signed(s1_q.partial[N-1:0])) - W_RED'($signed(s1_q.w[N-1:0])),
                       N, SATURATE != 0);
    s2_d         = s1_q;
    s2_d.partial = sub_r.val[N_MAX-1:0];
    s2_d.ovf     = s1_q.ovf | sub_r.ovf;

    s3_d         = s2_q;
    s3_d.partial = N_MAX'(p3);
    s3_d.ovf     = s2_q.ovf | ovf3;

    // w rides along from stage 1 so the accumulate needs no second RAM read.
    acc_r = sat_reduce(W_RED'(dw) + W_RED'($signed(s3_q.w[N-1:0])), N, SATURATE != 0);
    s4_d  = s3_q;
    if (ACCUM != 0) begin
      s4_d.partial = acc_r.val[N_MAX-1:0];
      s4_d.ovf     = s3_q.ovf | ovf4 | acc_r.ovf;
    end else begin
      s4_d.partial = N_MAX'(dw);
      s4_d.ovf     = s3_q.ovf | ovf4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      s4_q         <= '0;
      ovf_sticky_q <= 1'b0;
    end else if (!stall) begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      s4_q         <= s4_d;
      ovf_sticky_q <= ovf_sticky_q | (s4_d.valid & s4_d.ovf);
    end
  end

  assign bus.out_valid  = s4_q.valid;
  assign bus.out_ch     = s4_q.ch[CH_W-1:0];
  assign bus.out_data   = $signed(s4_q.partial[N-1:0]);
  assign bus.out_ovf    = s4_q.ovf;
  assign bus.ovf_sticky = ovf_sticky_q;
  assign unused_bits    = ^{s1_q, s2_q, s3_q, s4_q, sub_r, acc_r};
endmodule

// File: tb/tb_izh_dw_pipe.sv
// Drives three izh_dw_pipe configurations in lockstep against an arithmetic reference model.
module tb_izh_dw_pipe;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;

  typedef struct {
    longint ch;
    longint d[3];
    bit     o[3];
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  bit     lat_chk = 1'b1;
  exp_t   expq[$];
  exp_t   e;

  izh_dw_pipe_if bus0 ();
  izh_dw_pipe_if bus1 ();
  izh_dw_pipe_if bus2 ();

  // cfg0: SAT=1 ACCUM=1, cfg1: SAT=0 ACCUM=0, cfg2: SAT=1 ACCUM=0
  izh_dw_pipe #(.SATURATE(1), .ACCUM(1)) u_d0 (.clk(clk), .reset(reset), .bus(bus0));
  izh_dw_pipe #(.SATURATE(0), .ACCUM(0)) u_d1 (.clk(clk), .reset(reset), .bus(bus1));
  izh_dw_pipe #(.SATURATE(1), .ACCUM(0)) u_d2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_ch     = bus0.in_ch;
  assign bus1.in_a      = bus0.in_a;
  assign bus1.in_b      = bus0.in_b;
  assign bus1.in_v      = bus0.in_v;
  assign bus1.in_w      = bus0.in_w;
  assign bus1.in_step   = bus0.in_step;
  assign bus1.out_ready = bus0.out_ready;
  assign bus2.in_valid  = bus0.in_valid;
  assign bus2.in_ch     = bus0.in_ch;
  assign bus2.in_a      = bus0.in_a;
  assign bus2.in_b      = bus0.in_b;
  assign bus2.in_v      = bus0.in_v;
  assign bus2.in_w      = bus0.in_w;
  assign bus2.in_step   = bus0.in_step;
  assign bus2.out_ready = bus0.out_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // floor(p / 256)
  function automatic longint fdiv(input longint p);
    longint r;
    r = p % 256;
    if (r < 0) r += 256;
    return (p - r) / 256;
  endfunction

  function automatic longint red(input longint x, input bit sat, inout bit ovf);
    longint m;
    if (x >= MINV && x <= MAXV) return x;
    ovf = 1'b1;
    if (sat) return (x > MAXV) ? MAXV : MINV;
    m = ((x % 262144) + 262144) % 262144;
    if (m > MAXV) m -= 262144;
    return m;
  endfunction

  function automatic void model(input longint a, b, v, w, step, input bit sat, acc,
                                output longint d, output bit o);
    longint p1, p2, p3, dw;
    o  = 1'b0;
    p1 = red(fdiv(b * v), sat, o);
    p2 = red(p1 - w, sat, o);
    p3 = red(fdiv(a * p2), sat, o);
    dw = red(fdiv(p3 * step), sat, o);
    d  = acc ? red(w + dw, sat, o) : dw;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
    end else begin
      if (bus0.out_valid && bus0.out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_out", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          chk("out_ch", bus0.out_ch, e.ch);
          chk("d0_data", bus0.out_data, e.d[0]);
          chk("d0_ovf", bus0.out_ovf, e.o[0]);
          chk("d1_valid", bus1.out_valid, 1);
          chk("d1_data", bus1.out_data, e.d[1]);
          chk("d1_ovf", bus1.out_ovf, e.o[1]);
          chk("d2_data", bus2.out_data, e.d[2]);
          chk("d2_ovf", bus2.out_ovf, e.o[2]);
          if (lat_chk) chk("latency", cyc - e.cyc, 4);
        end
      end
      if (bus0.in_valid && bus0.in_ready) begin
        e.ch  = bus0.in_ch;
        e.cyc = cyc;
        for (int k = 0; k < 3; k++)
          model(bus0.in_a, bus0.in_b, bus0.in_v, bus0.in_w, bus0.in_step,
                k != 1, k == 0, e.d[k], e.o[k]);
        expq.push_back(e);
      end
    end
  end

  task automatic send(input int ch, input longint a, b, v, w, step);
    int n;
    bus0.in_valid = 1'b1;
    bus0.in_ch    = 8'(ch);
    bus0.in_a     = 18'(a);
    bus0.in_b     = 18'(b);
    bus0.in_v     = 18'(v);
    bus0.in_w     = 18'(w);
    bus0.in_step  = 18'(step);
    n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.in_ready) chk("send_accept", bus0.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.in_valid = 1'b0;
  endtask

  function automatic longint rop();
    case ($urandom_range(0, 3))
      0:       return longint'($urandom_range(0, 262143)) - 131072;
      1:       return longint'($urandom_range(0, 1023)) - 512;
      2:       return longint'($urandom_range(200, 300));
      default: return longint'($urandom_range(0, 40000)) - 20000;
    endcase
  endfunction

  task automatic stream(input int n, input int ch0);
    for (int i = 0; i < n; i++) send(ch0 + i, rop(), rop(), rop(), rop(), rop());
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) chk("drain", expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_ch     = '0;
    bus0.in_a      = '0;
    bus0.in_b      = '0;
    bus0.in_v      = '0;
    bus0.in_w      = '0;
    bus0.in_step   = '0;
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_out_data", bus0.out_data, 0);
    chk("rst_out_ch", bus0.out_ch, 0);
    chk("rst_out_ovf", bus0.out_ovf, 0);
    chk("rst_sticky", bus0.ovf_sticky, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus0.in_ready, 1);

    // Basic beat, checked at exactly t+4
    send(5, 256, 128, 512, 128, 256);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("basic_valid", bus0.out_valid, 1);
    chk("basic_acc1", bus0.out_data, 256);
    chk("basic_ch", bus0.out_ch, 5);
    chk("basic_ovf", bus0.out_ovf, 0);
    chk("basic_acc0", bus2.out_data, 128);
    drain();
    chk("basic_sticky", bus0.ovf_sticky, 0);

    // Saturation vs wrap of b*v
    send(9, 256, 25600, 25600, 0, 256);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sat_data", bus0.out_data, 131071);
    chk("sat_ovf", bus0.out_ovf, 1);
    chk("wrap_data", bus1.out_data, -61440);
    chk("wrap_ovf", bus1.out_ovf, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sticky", bus0.ovf_sticky, 1);
    chk("wrap_sticky", bus1.ovf_sticky, 1);
    chk("noovf_sticky_later", bus0.ovf_sticky, 1);

    // Negating the most negative w
    send(3, 256, 0, 0, -131072, 256);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("neg_data", bus2.out_data, 131071);
    chk("neg_ovf", bus2.out_ovf, 1);
    drain();

    // Back-to-back random stream, channels 0..63
    stream(64, 0);
    drain();

    // Backpressure: out_ready low for 3 cycles mid-stream
    lat_chk = 1'b0;
    fork
      stream(20, 100);
      begin
        repeat (8) @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready", bus0.in_ready, 0);
          chk("bp_out_valid", bus0.out_valid, 1);
          if (expq.size() > 0) begin
            chk("bp_hold_data", bus0.out_data, expq[0].d[0]);
            chk("bp_hold_ch", bus0.out_ch, expq[0].ch);
          end
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // Reset with four beats in flight; sticky forced high first
    send(200, 256, 25600, 25600, 0, 256);
    for (int i = 1; i < 4; i++) send(200 + i, rop(), rop(), rop(), rop(), rop());
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", bus0.out_valid, 0);
    chk("mid_rst_sticky", bus0.ovf_sticky, 0);
    chk("mid_rst_out_data", bus0.out_data, 0);
    chk("mid_rst_in_ready", bus0.in_ready, 1);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_mid_rst_quiet", bus0.out_valid, 0);

    stream(8, 40);
    drain();
    chk("final_queue", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
